stream_encryptor: RTL and testbench
===================================

Name: stream_encryptor

Overview:
Sequential front-end encryptor that feeds the combinational decryptor path.
- Accepts plaintext one byte per cycle over a valid/ready handshake.
- XORs each byte with a repeating SEC_LEN-byte secret key.
- Assembles the ciphertext into an MSG_LEN-byte frame buffer.
- Presents the frame as an unpacked byte array with a valid/ready output handshake; the output array format matches the decryptor's text_in port.

Parameters:
MSG_LEN, 20, frame length in bytes
SEC_LEN, 3, key length in bytes
PAD_BYTE, 8'h00, value written to unused frame positions after an early in_last; stored raw, not encrypted

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
key_load  in  1  latch key_in (honoured only in IDLE)
key_in  in  8*SEC_LEN  key bytes; key byte i = key_in[8*i+7:8*i]
in_valid  in  1  plaintext byte valid
in_ready  out  1  block can accept a byte
in_data  in  8  plaintext byte
in_last  in  1  qualifies the final byte of a short frame
out_valid  out  1  text_out holds a complete frame
out_ready  in  1  consumer takes the frame
text_out  out  [7:0] x [0:MSG_LEN-1]  ciphertext frame
out_len  out  $clog2(MSG_LEN+1)  count of real (non-pad) bytes in the frame
frame_cnt  out  16  completed frames handed off; wraps 16'hFFFF -> 0

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; key regs, text_out, out_len, frame_cnt, wr_idx and key_idx all 0.
  - out_valid=0.
  - in_ready follows the state rule below (1 while key_load=0).
  - Applies immediately, including mid-frame; a partial frame is discarded.
- Zero key: XOR with 0 is passthrough, so after reset the block passes plaintext through until a key is loaded.
- State machine, IDLE / LOAD / HOLD:
  - in_ready = (IDLE && !key_load) || LOAD. It is combinational from state and key_load.
- IDLE:
  - key_load=1 -> key regs <= key_in at the clock edge. Any in_valid that cycle is not accepted, because in_ready=0.
  - An accepted byte -> LOAD, or -> HOLD directly if it completes the frame.
- LOAD:
  - key_load is ignored.
  - Each accept (in_valid && in_ready): buf[wr_idx] <= in_data ^ key[key_idx].
  - wr_idx increments.
  - key_idx <= (key_idx==SEC_LEN-1) ? 0 : key_idx+1.
- Frame completion: the accept is of the MSG_LEN-th byte, or in_last=1 on the accepted byte.
  - state -> HOLD.
  - out_len <= bytes accepted, including this one.
  - All positions above the last written index <= PAD_BYTE, on the same edge.
  - out_valid=1 on the cycle after the completing accept (latency 1 from the final byte).
  - in_last on the MSG_LEN-th byte has no extra effect.
  - in_last with in_valid=0 is ignored.
- HOLD:
  - in_ready=0; text_out and out_len held stable.
  - out_valid && out_ready -> IDLE, out_valid=0, frame_cnt+1, wr_idx=0, key_idx=0.
  - The key index restarts at 0 on every frame.
- Arithmetic: byte-wide XOR only, no carries. key_idx is mod SEC_LEN. wr_idx never exceeds MSG_LEN-1.
- Byte rate: one byte per cycle maximum. Back-to-back accepts in LOAD are required (no bubbles).
- Simultaneous events:
  - key_load in LOAD/HOLD has no effect.
  - out_ready while out_valid=0 has no effect.
  - A new frame's first byte can be accepted no earlier than the cycle after the HOLD handoff.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle -> out_valid=0, text_out all 0, frame_cnt=0, in_ready=1 immediately.
- Full frame: key_load with key "KEY" (4B,45,59), then 20 consecutive 'A' (0x41) -> text_out = 0A,04,18 repeating, text_out[19]=04; out_valid rises exactly 1 cycle after the 20th accept; out_len=20.
- Short frame: "HELLO" with in_last on 'O' -> text_out[0..4] = 03,00,15,07,0A; [5..19]=00; out_len=5.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 -> in_ready=0, text_out stable, no byte consumed. Then pulse out_ready -> frame_cnt=1. The next frame's first 'A' encrypts to 0A (key_idx restarted).
- Key handling:
  - key_load together with in_valid in IDLE -> key updated, byte not accepted (in_ready=0), byte accepted the next cycle with the new key.
  - key_load during LOAD -> ciphertext still uses the old key.
- Reset mid-frame: after 7 bytes, pulse rst_n low -> buffer cleared, key=0. A following 20-byte frame of 'A' yields text_out all 0x41 (passthrough).

Source files
------------

// File: rtl/stream_encryptor.sv
// -----------------------------------------------------------------------------
// stream_encryptor
//   Byte-serial XOR stream encryptor. Plaintext bytes arrive one per cycle over
//   a valid/ready handshake, are XORed with a repeating SEC_LEN-byte key and are
//   packed into an MSG_LEN-byte frame. The completed frame is presented as an
//   unpacked byte array (same shape as the decryptor's text_in) with a
//   valid/ready output handshake.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   key_load   in   latch key_in (honoured only while idle)
//   key_in     in   key bytes, byte i = key_in[8*i+7:8*i]
//   in_valid   in   plaintext byte valid
//   in_ready   out  block can accept a byte this cycle
//   in_data    in   plaintext byte
//   in_last    in   marks the final byte of a short frame
//   out_valid  out  text_out holds a complete frame
//   out_ready  in   consumer takes the frame
//   text_out   out  ciphertext frame, MSG_LEN bytes
//   out_len    out  number of real (non-pad) bytes in the frame
//   frame_cnt  out  frames handed off, wraps at 16 bits
// -----------------------------------------------------------------------------
module stream_encryptor #(
  parameter int         MSG_LEN  = 20,
  parameter int         SEC_LEN  = 3,
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         key_load,
  input  logic [8*SEC_LEN-1:0]         key_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   text_out [0:MSG_LEN-1],
  output logic [$clog2(MSG_LEN+1)-1:0] out_len,
  output logic [15:0]                  frame_cnt
);

  localparam int IW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int KW = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1;
  localparam int LW = $clog2(MSG_LEN + 1);

  localparam logic [IW-1:0] LAST_IDX = IW'(MSG_LEN - 1);
  localparam logic [KW-1:0] LAST_KEY = KW'(SEC_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t          state_q,     state_d;
  logic [7:0]      key_q       [0:SEC_LEN-1];
  logic [7:0]      key_d       [0:SEC_LEN-1];
  logic [7:0]      buf_q       [0:MSG_LEN-1];
  logic [7:0]      buf_d       [0:MSG_LEN-1];
  logic [IW-1:0]   wr_idx_q,    wr_idx_d;
  logic [KW-1:0]   key_idx_q,   key_idx_d;
  logic [LW-1:0]   out_len_q,   out_len_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            out_valid_q, out_valid_d;

  logic            accept;
  logic            complete;
  logic            handoff;

  // Handshake qualifiers shared by the FSM and the datapath
  always_comb begin
    accept   = in_valid && in_ready;
    // The MSG_LEN-th byte ends the frame whether or not in_last is set
    complete = accept && ((wr_idx_q == LAST_IDX) || in_last);
    // out_valid is only ever high in HOLD, so this is the HOLD exit condition
    handoff  = out_valid_q && out_ready;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (complete) begin
          state_d = ST_HOLD;
        end else if (accept) begin
          state_d = ST_LOAD;
        end else begin
          state_d = state_q;
        end
      end
      ST_HOLD: begin
        if (handoff) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output logic: in_ready drops while a key is being latched in IDLE
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = !key_load;
      ST_LOAD: in_ready = 1'b1;
      ST_HOLD: in_ready = 1'b0;
      default: in_ready = 1'b0;
    endcase
  end

  // Datapath next-state: key latch, encrypt-and-store, padding, handoff
  always_comb begin
    key_d       = key_q;
    buf_d       = buf_q;
    wr_idx_d    = wr_idx_q;
    key_idx_d   = key_idx_q;
    out_len_d   = out_len_q;
    frame_cnt_d = frame_cnt_q;
    out_valid_d = out_valid_q;

    if ((state_q == ST_IDLE) && key_load) begin
      for (int k = 0; k < SEC_LEN; k++) begin
        key_d[k] = key_in[8*k +: 8];
      end
    end else begin
      key_d = key_q;
    end

    if (accept) begin
      buf_d[wr_idx_q] = in_data ^ key_q[key_idx_q];
      key_idx_d       = (key_idx_q == LAST_KEY) ? {KW{1'b0}} : key_idx_q + KW'(1);
      // Hold the index on the completing byte so it never passes LAST_IDX
      wr_idx_d        = complete ? wr_idx_q : wr_idx_q + IW'(1);
    end else begin
      wr_idx_d = wr_idx_q;
    end

    if (complete) begin
      out_len_d   = LW'(wr_idx_q) + LW'(1);
      out_valid_d = 1'b1;
      // Pad everything above the byte written on this edge
      for (int i = 0; i < MSG_LEN; i++) begin
        if (i > int'(wr_idx_q)) begin
          buf_d[i] = PAD_BYTE;
        end else begin
          buf_d[i] = buf_d[i];
        end
      end
    end else begin
      out_len_d = out_len_q;
    end

    if (handoff) begin
      out_valid_d = 1'b0;
      frame_cnt_d = frame_cnt_q + 16'd1;
      wr_idx_d    = {IW{1'b0}};
      key_idx_d   = {KW{1'b0}};
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SEC_LEN; k++) begin
        key_q[k] <= 8'h00;
      end
      for (int i = 0; i < MSG_LEN; i++) begin
        buf_q[i] <= 8'h00;
      end
      wr_idx_q    <= {IW{1'b0}};
      key_idx_q   <= {KW{1'b0}};
      out_len_q   <= {LW{1'b0}};
      frame_cnt_q <= 16'd0;
      out_valid_q <= 1'b0;
    end else begin
      key_q       <= key_d;
      buf_q       <= buf_d;
      wr_idx_q    <= wr_idx_d;
      key_idx_q   <= key_idx_d;
      out_len_q   <= out_len_d;
      frame_cnt_q <= frame_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign text_out  = buf_q;
  assign out_len   = out_len_q;
  assign frame_cnt = frame_cnt_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_encryptor.sv
module tb_stream_encryptor;

  localparam int MSG_LEN = 20;
  localparam int SEC_LEN = 3;

  logic        clk;
  logic        rst_n;
  logic        key_load;
  logic [23:0] key_in;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  text_out [0:MSG_LEN-1];
  logic [4:0]  out_len;
  logic [15:0] frame_cnt;

  int checks = 0;
  int passed = 0;

  // Reference model state
  logic [7:0]  mkey [0:SEC_LEN-1];
  int          m_fcnt = 0;
  logic [7:0]  pt_q [$];
  logic [7:0]  exp_frame [0:MSG_LEN-1];
  int          exp_len;
  logic        ov_before;

  stream_encryptor #(.MSG_LEN(MSG_LEN), .SEC_LEN(SEC_LEN), .PAD_BYTE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .text_out(text_out),
    .out_len(out_len), .frame_cnt(frame_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frame = plaintext byte i XOR key byte (i mod SEC_LEN), rest zero-padded
  function automatic void build_expected();
    for (int i = 0; i < MSG_LEN; i++) begin
      if (i < pt_q.size()) exp_frame[i] = pt_q[i] ^ mkey[i % SEC_LEN];
      else                 exp_frame[i] = 8'h00;
    end
    exp_len = pt_q.size();
  endfunction

  function automatic int frame_diff();
    for (int i = 0; i < MSG_LEN; i++) begin
      if (text_out[i] !== exp_frame[i]) return i;
    end
    return -1;
  endfunction

  function automatic void set_model_key(input logic [23:0] k);
    for (int i = 0; i < SEC_LEN; i++) mkey[i] = k[8*i +: 8];
  endfunction

  // Present one byte from a negedge; returns at the negedge after it is taken
  task automatic drive_byte(input logic [7:0] d, input logic last, output logic ok);
    ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = last;
    for (int c = 0; c < 40; c++) begin
      #1;
      ov_before = out_valid;
      if (in_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input logic use_last, output int acc);
    logic ok;
    acc = 0;
    for (int i = 0; i < pt_q.size(); i++) begin
      drive_byte(pt_q[i], use_last && (i == pt_q.size() - 1), ok);
      if (ok) acc++;
    end
  endtask

  task automatic handoff(output logic seen);
    seen = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (out_valid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    out_ready = 1'b0;
    if (seen) m_fcnt++;
  endtask

  task automatic test_reset();
    int nz;
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    nz = 0;
    for (int i = 0; i < MSG_LEN; i++) if (text_out[i] !== 8'h00) nz++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    checks++; if (nz != 0) $display("FAIL reset_text_out: %0d nonzero bytes want 0", nz); else passed++;
    checks++; if (frame_cnt !== 16'd0) $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); else passed++;
    checks++; if (out_len !== 5'd0) $display("FAIL reset_out_len: got %0d want 0", out_len); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    set_model_key(24'h0); m_fcnt = 0;
  endtask

  task automatic test_full_frame();
    int acc, d;
    @(negedge clk);
    key_load = 1'b1; key_in = 24'h59454B;
    #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL keyload_in_ready: got %b want 0", in_ready); else passed++;
    @(negedge clk);
    key_load = 1'b0;
    set_model_key(24'h59454B);
    pt_q = {};
    for (int i = 0; i < MSG_LEN; i++) pt_q.push_back(8'h41);
    build_expected();
    send_frame(1'b0, acc);
    d = frame_diff();
    checks++; if (acc != 20) $display("FAIL full_accepts: got %0d want 20", acc); else passed++;
    checks++; if (ov_before !== 1'b0) $display("FAIL full_latency_early: out_valid %b want 0 before last edge", ov_before); else passed++;
    checks++; if (out_valid !== 1'b1) $display("FAIL full_latency: out_valid %b want 1", out_valid); else passed++;
    checks++; if (d != -1) $display("FAIL full_frame: byte %0d got %h want %h", d, text_out[d], exp_frame[d]); else passed++;
    checks++; if (out_len !== 5'd20) $display("FAIL full_out_len: got %0d want 20", out_len); else passed++;
    checks++;
    if (text_out[0] !== 8'h0A || text_out[1] !== 8'h04 || text_out[2] !== 8'h18 || text_out[19] !== 8'h04)
      $display("FAIL full_known: got %h %h %h %h want 0a 04 18 04", text_out[0], text_out[1], text_out[2], text_out[19]);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [7:0] snap [0:MSG_LEN-1];
    int bad_rdy, bad_txt, acc;
    logic seen;
    snap = text_out;
    bad_rdy = 0; bad_txt = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_data = 8'($urandom);
      #1;
      if (in_ready !== 1'b0) bad_rdy++;
      for (int i = 0; i < MSG_LEN; i++) if (text_out[i] !== snap[i]) bad_txt++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (bad_rdy != 0) $display("FAIL bp_in_ready: %0d cycles high want 0", bad_rdy); else passed++;
    checks++; if (bad_txt != 0) $display("FAIL bp_text_stable: %0d changed bytes want 0", bad_txt); else passed++;
    checks++; if (frame_cnt !== 16'd0) $display("FAIL bp_frame_cnt_hold: got %0d want 0", frame_cnt); else passed++;
    handoff(seen);
    checks++; if (frame_cnt !== 16'(m_fcnt) || !seen) $display("FAIL bp_frame_cnt: got %0d want %0d", frame_cnt, m_fcnt); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_out_valid_clear: got %b want 0", out_valid); else passed++;
    pt_q = {8'h41};
    build_expected();
    send_frame(1'b1, acc);
    checks++; if (text_out[0] !== 8'h0A) $display("FAIL bp_key_restart: got %h want 0a", text_out[0]); else passed++;
    checks++; if (frame_diff() != -1 || out_len !== 5'd1) $display("FAIL bp_single: out_len %0d want 1", out_len); else passed++;
    handoff(seen);
  endtask

  task automatic test_short_frame();
    int acc, d;
    logic seen;
    pt_q = {8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    build_expected();
    send_frame(1'b1, acc);
    d = frame_diff();
    checks++; if (acc != 5 || out_len !== 5'd5) $display("FAIL short_len: acc %0d out_len %0d want 5", acc, out_len); else passed++;
    checks++; if (d != -1) $display("FAIL short_frame: byte %0d got %h want %h", d, text_out[d], exp_frame[d]); else passed++;
    checks++;
    if (text_out[0] !== 8'h03 || text_out[1] !== 8'h00 || text_out[2] !== 8'h15 || text_out[3] !== 8'h07 || text_out[4] !== 8'h0A)
      $display("FAIL short_known: got %h %h %h %h %h want 03 00 15 07 0a", text_out[0], text_out[1], text_out[2], text_out[3], text_out[4]);
    else passed++;
    handoff(seen);
    checks++; if (frame_cnt !== 16'(m_fcnt)) $display("FAIL short_frame_cnt: got %0d want %0d", frame_cnt, m_fcnt); else passed++;
  endtask

  task automatic test_key_load_idle();
    logic [23:0] nk;
    logic [7:0]  d;
    logic        ok, seen;
    // out_ready with nothing pending must not count a frame
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (frame_cnt !== 16'(m_fcnt)) $display("FAIL idle_out_ready: frame_cnt %0d want %0d", frame_cnt, m_fcnt); else passed++;
    nk = 24'($urandom);
    d  = 8'($urandom);
    key_load = 1'b1; key_in = nk; in_valid = 1'b1; in_data = d; in_last = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL kl_idle_in_ready: got %b want 0", in_ready); else passed++;
    @(negedge clk);
    key_load = 1'b0;
    set_model_key(nk);
    pt_q = {d};
    build_expected();
    drive_byte(d, 1'b1, ok);
    checks++; if (!ok || frame_diff() != -1 || out_len !== 5'd1)
      $display("FAIL kl_idle_newkey: got %h len %0d want %h len 1", text_out[0], out_len, exp_frame[0]);
    else passed++;
    handoff(seen);
  endtask

  task automatic test_key_load_in_load();
    logic ok, seen;
    int acc, d;
    pt_q = {};
    for (int i = 0; i < 6; i++) pt_q.push_back(8'($urandom));
    build_expected();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin key_load = 1'b1; key_in = ~{mkey[2], mkey[1], mkey[0]}; end
      drive_byte(pt_q[i], i == 5, ok);
      if (ok) acc++;
    end
    key_load = 1'b0;
    d = frame_diff();
    checks++; if (acc != 6) $display("FAIL kl_load_accepts: got %0d want 6", acc); else passed++;
    checks++; if (d != -1) $display("FAIL kl_load_oldkey: byte %0d got %h want %h", d, text_out[d], exp_frame[d]); else passed++;
    handoff(seen);
  endtask

  task automatic test_back_to_back();
    int acc, d, len, cyc;
    logic use_last, seen;
    longint t0;
    for (int f = 0; f < 8; f++) begin
      if ($urandom_range(1, 0) == 1) begin
        @(negedge clk);
        key_in = 24'($urandom); key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
        set_model_key(key_in);
      end
      len = $urandom_range(MSG_LEN, 1);
      use_last = (len < MSG_LEN) ? 1'b1 : 1'($urandom);
      pt_q = {};
      for (int i = 0; i < len; i++) pt_q.push_back(8'($urandom));
      build_expected();
      t0 = $time;
      send_frame(use_last, acc);
      cyc = int'(($time - t0) / 10);
      d = frame_diff();
      checks++; if (cyc != len || acc != len) $display("FAIL b2b_rate: %0d cycles for %0d bytes", cyc, len); else passed++;
      checks++; if (d != -1) $display("FAIL b2b_frame: byte %0d got %h want %h", d, text_out[d], exp_frame[d]); else passed++;
      checks++; if (out_len !== 5'(exp_len) || out_valid !== 1'b1) $display("FAIL b2b_len: got %0d want %0d", out_len, exp_len); else passed++;
      repeat ($urandom_range(3, 0)) @(negedge clk);
      handoff(seen);
      checks++; if (frame_cnt !== 16'(m_fcnt)) $display("FAIL b2b_frame_cnt: got %0d want %0d", frame_cnt, m_fcnt); else passed++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int acc, nz, d;
    logic seen;
    pt_q = {};
    for (int i = 0; i < 7; i++) pt_q.push_back(8'($urandom));
    send_frame(1'b0, acc);
    #2 rst_n = 1'b0;
    #1;
    nz = 0;
    for (int i = 0; i < MSG_LEN; i++) if (text_out[i] !== 8'h00) nz++;
    checks++; if (nz != 0 || frame_cnt !== 16'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL midrst_state: nz %0d cnt %0d ov %b rdy %b want 0 0 0 1", nz, frame_cnt, out_valid, in_ready);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    set_model_key(24'h0); m_fcnt = 0;
    pt_q = {};
    for (int i = 0; i < MSG_LEN; i++) pt_q.push_back(8'h41);
    build_expected();
    send_frame(1'b0, acc);
    d = frame_diff();
    checks++; if (d != -1 || text_out[7] !== 8'h41) $display("FAIL midrst_passthru: byte %0d got %h want 41", (d < 0) ? 7 : d, text_out[(d < 0) ? 7 : d]); else passed++;
    checks++; if (out_len !== 5'd20) $display("FAIL midrst_len: got %0d want 20", out_len); else passed++;
    handoff(seen);
    checks++; if (frame_cnt !== 16'd1) $display("FAIL midrst_frame_cnt: got %0d want 1", frame_cnt); else passed++;
  endtask

  initial begin
    rst_n = 1'b0; key_load = 1'b0; key_in = 24'h0; in_valid = 1'b0;
    in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    set_model_key(24'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_short_frame();
    test_key_load_idle();
    test_key_load_in_load();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
